// File: rtl/transaction_timer_pkg.sv
// Shared types for the transaction timer bank: channel state, capture record, index width helper.
package transaction_timer_pkg;

    // Widest counter the capture record can carry; COUNT_SIZE must not exceed this.
    localparam int TT_VALUE_W = 64;

    typedef enum logic [1:0] {IDLE, RUNNING, DONE} ch_state_t;

    typedef struct packed {
        logic [TT_VALUE_W-1:0] value;
        logic                  overflow;
        logic                  timeout;
    } cap_rec_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/transaction_timer_bank_if.sv
// Capture port of the timer bank: one registered record per valid/ready handshake.
interface transaction_timer_bank_if #(
    parameter int CH_W       = 2,
    parameter int COUNT_SIZE = 32
) ();
    logic                  o_cap_valid;
    logic                  i_cap_ready;
    logic [CH_W-1:0]       o_cap_ch;
    logic [COUNT_SIZE-1:0] o_cap_value;
    logic                  o_cap_overflow;
    logic                  o_cap_timeout;

    modport master (output o_cap_valid, o_cap_ch, o_cap_value, o_cap_overflow, o_cap_timeout,
                    input  i_cap_ready);
    modport slave  (input  o_cap_valid, o_cap_ch, o_cap_value, o_cap_overflow, o_cap_timeout,
                    output i_cap_ready);
endinterface

// File: rtl/transaction_timer_bank_timer_channel.sv
// One elapsed-cycle timer: IDLE -> RUNNING -> DONE -> IDLE, counter frozen while DONE.
// TT_TIMEOUT_EN adds a timeout threshold that ends a measurement without a stop strobe.
module timer_channel
    import transaction_timer_pkg::*;
#(
    parameter int COUNT_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  saturate,
    input  logic                  retire,
`ifdef TT_TIMEOUT_EN
    input  logic [COUNT_SIZE-1:0] timeout_value,
`endif
    output logic                  busy,
    output logic                  done,
    output cap_rec_t              rec
);

    ch_state_t             state, state_nxt;
    logic [COUNT_SIZE-1:0] count, count_nxt;
    logic                  ovf, ovf_nxt, tmo, tmo_nxt, tmo_hit;

`ifdef TT_TIMEOUT_EN
    assign tmo_hit = (timeout_value != '0) && (count == timeout_value);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            ovf   <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
            tmo   <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        ovf_nxt   = ovf;
        tmo_nxt   = tmo;
        if (clear) begin
            state_nxt = IDLE;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            tmo_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_nxt = RUNNING;
                    count_nxt = COUNT_SIZE'(1);
                    ovf_nxt   = 1'b0;
                    tmo_nxt   = 1'b0;
                end
                RUNNING: begin
                    // The count visible this cycle is the measurement; stop beats timeout.
                    if (stop) begin
                        state_nxt = DONE;
                        tmo_nxt   = 1'b0;
                    end else if (tmo_hit) begin
                        state_nxt = DONE;
                        tmo_nxt   = 1'b1;
                    end else if (&count) begin
                        ovf_nxt   = 1'b1;
                        count_nxt = saturate ? count : '0;
                    end else begin
                        count_nxt = count + COUNT_SIZE'(1);
                    end
                end
                DONE:    if (retire) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state == RUNNING);
    assign done = (state == DONE);
    assign rec  = '{value: TT_VALUE_W'(count), overflow: ovf, timeout: tmo};

endmodule

// File: rtl/transaction_timer_bank.sv
// Bank of NUM_CH timers draining finished measurements through a fixed-priority registered capture port.
// Optional feature macro: TT_TIMEOUT_EN (adds i_timeout_value and drives o_cap_timeout).
module transaction_timer_bank
    import transaction_timer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int COUNT_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     i_start,
    input  logic [NUM_CH-1:0]     i_stop,
    input  logic [NUM_CH-1:0]     i_clear,
    input  logic                  i_saturate,
`ifdef TT_TIMEOUT_EN
    input  logic [COUNT_SIZE-1:0] i_timeout_value,
`endif
    output logic [NUM_CH-1:0]     o_busy,
    transaction_timer_bank_if.master cap
);

    localparam int CH_W = ch_w(NUM_CH);

    logic [NUM_CH-1:0]    done_vec, presented, retire, eligible;
    cap_rec_t [NUM_CH-1:0] recs;
    logic                 handshake, clear_presented, gnt_any, cap_tmo;
    logic [CH_W-1:0]      gnt_idx;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(.COUNT_SIZE(COUNT_SIZE)) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .start         (i_start[g]),
            .stop          (i_stop[g]),
            .clear         (i_clear[g]),
            .saturate      (i_saturate),
            .retire        (retire[g]),
`ifdef TT_TIMEOUT_EN
            .timeout_value (i_timeout_value),
`endif
            .busy          (o_busy[g]),
            .done          (done_vec[g]),
            .rec           (recs[g])
        );
    end

    assign handshake = cap.o_cap_valid & cap.i_cap_ready;

    always_comb begin
        presented = '0;
        if (cap.o_cap_valid) presented[cap.o_cap_ch] = 1'b1;
        clear_presented = |(presented & i_clear);
        retire   = handshake ? presented : '0;
        // The presented channel is either retiring or still owns the port; never re-grant it.
        eligible = done_vec & ~presented & ~i_clear;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap.o_cap_valid    <= 1'b0;
            cap.o_cap_ch       <= '0;
            cap.o_cap_value    <= '0;
            cap.o_cap_overflow <= 1'b0;
            cap_tmo            <= 1'b0;
        end else if (clear_presented) begin
            cap.o_cap_valid <= 1'b0;
        end else if (!cap.o_cap_valid || handshake) begin
            cap.o_cap_valid <= gnt_any;
            if (gnt_any) begin
                cap.o_cap_ch       <= gnt_idx;
                cap.o_cap_value    <= recs[gnt_idx].value[COUNT_SIZE-1:0];
                cap.o_cap_overflow <= recs[gnt_idx].overflow;
                cap_tmo            <= recs[gnt_idx].timeout;
            end
        end
    end

`ifdef TT_TIMEOUT_EN
    assign cap.o_cap_timeout = cap_tmo;
`else
    assign cap.o_cap_timeout = 1'b0;
`endif

    // Upper record bits beyond COUNT_SIZE are always zero.
    logic unused_bits;
    assign unused_bits = ^{recs, cap_tmo};

endmodule

// File: tb/tb_transaction_timer_bank.sv
// Directed bench: a 4-channel 32-bit bank and a 2-channel 4-bit bank for wrap/saturate limits.
module tb_transaction_timer_bank;
    import transaction_timer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start_a, stop_a, clear_a, busy_a;
    logic [1:0] start_b, stop_b, clear_b, busy_b;
    logic       sat_a, sat_b;
`ifdef TT_TIMEOUT_EN
    logic [31:0] tmo_a;
    logic [3:0]  tmo_b;
`endif

    transaction_timer_bank_if #(.CH_W(2), .COUNT_SIZE(32)) cap_a ();
    transaction_timer_bank_if #(.CH_W(1), .COUNT_SIZE(4))  cap_b ();

    transaction_timer_bank #(.NUM_CH(4), .COUNT_SIZE(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(start_a), .i_stop(stop_a), .i_clear(clear_a),
        .i_saturate(sat_a),
`ifdef TT_TIMEOUT_EN
        .i_timeout_value(tmo_a),
`endif
        .o_busy(busy_a), .cap(cap_a));

    transaction_timer_bank #(.NUM_CH(2), .COUNT_SIZE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(start_b), .i_stop(stop_b), .i_clear(clear_b),
        .i_saturate(sat_b),
`ifdef TT_TIMEOUT_EN
        .i_timeout_value(tmo_b),
`endif
        .o_busy(busy_b), .cap(cap_b));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int sel;   // 0: 32-bit bank, 1: 4-bit bank
        int ch;
        int len;
        bit sat;
        int exp_val;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_meas(input vec_t v);
        logic [31:0] val;
        if (v.sel == 0) begin
            sat_a = v.sat; start_a[v.ch] = 1'b1;
        end else begin
            sat_b = v.sat; start_b[v.ch] = 1'b1;
        end
        tick();
        start_a = '0; start_b = '0;
        repeat (v.len - 1) tick();
        check("busy_running", v.sel == 0 ? 32'(busy_a[v.ch]) : 32'(busy_b[v.ch]), 32'd1);
        if (v.sel == 0) stop_a[v.ch] = 1'b1; else stop_b[v.ch] = 1'b1;
        tick();
        stop_a = '0; stop_b = '0;
        check("busy_done", v.sel == 0 ? 32'(busy_a[v.ch]) : 32'(busy_b[v.ch]), 32'd0);
        check("valid_first_done", v.sel == 0 ? 32'(cap_a.o_cap_valid) : 32'(cap_b.o_cap_valid), 32'd0);
        tick();
        val = (v.sel == 0) ? cap_a.o_cap_value : 32'(cap_b.o_cap_value);
        check("rec_valid", v.sel == 0 ? 32'(cap_a.o_cap_valid) : 32'(cap_b.o_cap_valid), 32'd1);
        check("rec_ch", v.sel == 0 ? 32'(cap_a.o_cap_ch) : 32'(cap_b.o_cap_ch), 32'(v.ch));
        check("rec_value", val, 32'(v.exp_val));
        check("rec_ovf", v.sel == 0 ? 32'(cap_a.o_cap_overflow) : 32'(cap_b.o_cap_overflow),
              32'(v.exp_ovf));
        tick();
        check("rec_retired", v.sel == 0 ? 32'(cap_a.o_cap_valid) : 32'(cap_b.o_cap_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 10, 1'b0, 10, 1'b0};
        vecs[1] = '{0, 1, 1,  1'b0, 1,  1'b0};
        vecs[2] = '{0, 2, 2,  1'b0, 2,  1'b0};
        vecs[3] = '{0, 3, 37, 1'b0, 37, 1'b0};
        vecs[4] = '{1, 0, 20, 1'b0, 4,  1'b1};
        vecs[5] = '{1, 1, 20, 1'b1, 15, 1'b1};
        vecs[6] = '{1, 0, 15, 1'b0, 15, 1'b0};
        vecs[7] = '{1, 1, 16, 1'b0, 0,  1'b1};
        vecs[8] = '{1, 0, 17, 1'b1, 15, 1'b1};

        rst_n = 1'b0;
        start_a = '0; stop_a = '0; clear_a = '0; sat_a = 1'b0;
        start_b = '0; stop_b = '0; clear_b = '0; sat_b = 1'b0;
        cap_a.i_cap_ready = 1'b0; cap_b.i_cap_ready = 1'b0;
`ifdef TT_TIMEOUT_EN
        tmo_a = '0; tmo_b = '0;
`endif
        tick(); tick();
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_valid_a", 32'(cap_a.o_cap_valid), 32'd0);
        check("rst_value_a", cap_a.o_cap_value, 32'd0);
        check("rst_valid_b", 32'(cap_b.o_cap_valid), 32'd0);
        rst_n = 1'b1;
        cap_a.i_cap_ready = 1'b1; cap_b.i_cap_ready = 1'b1;
        tick();

        foreach (vecs[i]) run_meas(vecs[i]);

        // Two channels finish together behind a stalled port.
        cap_a.i_cap_ready = 1'b0;
        start_a = 4'b0110; tick(); start_a = '0;
        repeat (4) tick();
        stop_a = 4'b0110; tick(); stop_a = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(cap_a.o_cap_valid), 32'd1);
            check("stall_ch", 32'(cap_a.o_cap_ch), 32'd1);
            check("stall_value", cap_a.o_cap_value, 32'd5);
            tick();
        end
        cap_a.i_cap_ready = 1'b1;
        check("b2b_first_ch", 32'(cap_a.o_cap_ch), 32'd1);
        tick();
        check("b2b_second_valid", 32'(cap_a.o_cap_valid), 32'd1);
        check("b2b_second_ch", 32'(cap_a.o_cap_ch), 32'd2);
        check("b2b_second_value", cap_a.o_cap_value, 32'd5);
        tick();
        check("b2b_drained", 32'(cap_a.o_cap_valid), 32'd0);

        // start+stop priorities, then clear of the presented channel.
        cap_a.i_cap_ready = 1'b0;
        start_a = 4'b0001; stop_a = 4'b0001; tick();
        check("idle_start_stop_runs", 32'(busy_a[0]), 32'd1);
        start_a = '0; stop_a = '0; tick();
        start_a = 4'b0001; stop_a = 4'b0001; tick();
        start_a = '0; stop_a = '0;
        check("run_start_stop_done", 32'(busy_a[0]), 32'd0);
        tick();
        check("pre_clear_valid", 32'(cap_a.o_cap_valid), 32'd1);
        check("pre_clear_value", cap_a.o_cap_value, 32'd2);
        clear_a = 4'b0001; tick(); clear_a = '0;
        check("clear_drops_valid", 32'(cap_a.o_cap_valid), 32'd0);
        tick();
        check("clear_no_regrant", 32'(cap_a.o_cap_valid), 32'd0);
        start_a = 4'b0001; tick(); start_a = '0;
        tick(); tick();
        stop_a = 4'b0001; tick(); stop_a = '0;
        cap_a.i_cap_ready = 1'b1;
        tick();
        check("restart_valid", 32'(cap_a.o_cap_valid), 32'd1);
        check("restart_value", cap_a.o_cap_value, 32'd3);
        tick();
        check("restart_retired", 32'(cap_a.o_cap_valid), 32'd0);

        // Reset in the middle of activity.
        cap_a.i_cap_ready = 1'b0;
        start_a = 4'b1111; tick(); start_a = '0;
        stop_a = 4'b1000; tick(); stop_a = '0;
        tick();
        check("pre_rst_valid", 32'(cap_a.o_cap_valid), 32'd1);
        check("pre_rst_busy", 32'(busy_a), 32'h7);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_valid", 32'(cap_a.o_cap_valid), 32'd0);
        check("midrst_ch", 32'(cap_a.o_cap_ch), 32'd0);
        check("midrst_value", cap_a.o_cap_value, 32'd0);
        check("midrst_ovf", 32'(cap_a.o_cap_overflow), 32'd0);
        check("midrst_tmo", 32'(cap_a.o_cap_timeout), 32'd0);
        cap_a.i_cap_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_no_stale", 32'({busy_a, cap_a.o_cap_valid}), 32'd0);
        end

`ifdef TT_TIMEOUT_EN
        begin
            int k;
            tmo_a = 32'd7;
            start_a = 4'b0001; tick(); start_a = '0;
            k = 1;
            while (!cap_a.o_cap_valid && k < 30) begin
                tick();
                k++;
            end
            check("tmo_latency", 32'(k), 32'd9);
            check("tmo_value", cap_a.o_cap_value, 32'd7);
            check("tmo_flag", 32'(cap_a.o_cap_timeout), 32'd1);
            tick();
            tmo_a = 32'd4;
            start_a = 4'b0100; tick(); start_a = '0;
            tick(); tick(); tick();
            stop_a = 4'b0100; tick(); stop_a = '0;
            tick();
            check("tmo_stop_value", cap_a.o_cap_value, 32'd4);
            check("tmo_stop_flag", 32'(cap_a.o_cap_timeout), 32'd0);
            tick();
            tmo_a = 32'd0;
            start_a = 4'b0010; tick(); start_a = '0;
            repeat (20) tick();
            check("tmo_zero_no_rec", 32'(cap_a.o_cap_valid), 32'd0);
            check("tmo_zero_running", 32'(busy_a[1]), 32'd1);
            clear_a = 4'b0010; tick(); clear_a = '0;
        end
`else
        check("tmo_tied_low", 32'(cap_a.o_cap_timeout), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
